// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant controller.
package arb_pkg;

    localparam int N_DEF        = 8;
    localparam int IDXW_DEF     = $clog2(N_DEF);
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {IDLE, OWN, REL} arb_state_t;

    function automatic logic [IDXW_DEF-1:0] onehot_to_idx(input logic [N_DEF-1:0] v);
        onehot_to_idx = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (v[i]) onehot_to_idx = IDXW_DEF'(i);
        end
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational first-one encoder: the lowest set bit of req wins.
module prio_enc_n #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Walk from the top down so the lowest set index is the last write.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with grant hold, one-cycle release turnaround and a
// hold-timeout watchdog; gnt_idx drives the resource mux select.
module rr_grant_ctrl
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HCW = $clog2(MAX_HOLD + 1);

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] owner;
    logic [HCW-1:0]  hold_cnt;

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IDXW-1:0] enc_idx;
    logic            enc_any;
    logic [IDXW-1:0] win_idx;
    logic            expire;
    logic            release_now;

    // Rotate so that index ptr lands at bit 0, then map the winner back.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];
    assign win_idx = enc_idx + ptr;

    prio_enc_n #(
        .N    (N),
        .IDXW (IDXW)
    ) u_prio_enc (
        .req (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign expire      = (hold_cnt == HCW'(MAX_HOLD - 1));
    assign release_now = done || !req[owner] || expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (enc_any) begin
                        state     <= OWN;
                        owner     <= win_idx;
                        gnt       <= N'(1) << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        state     <= REL;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        // A completion landing on the expiry cycle wins over the watchdog.
                        timeout   <= expire && !done;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                REL: begin
                    state    <= IDLE;
                    ptr      <= owner + IDXW'(1);
                    hold_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
